// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, ROM addressing and the IF/ID pipeline register.
// Optional performance counters (fetch_cnt, stall_cnt) are enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter logic [31:0] BUBBLE_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [31:0] pc_p0;
    logic        advance;

    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    assign rom_addr = pc_p0;
    assign advance  = !redirect && !stall;

    // p0: PC register; a redirect overrides a concurrent stall
    always_ff @(posedge clk) begin
        if (rst)
            pc_p0 <= RESET_PC;
        else if (redirect)
            pc_p0 <= word_align(redirect_pc);
        else if (!stall)
            pc_p0 <= pc_inc(pc_p0);
    end

    // p1: IF/ID register; the instruction fetched during a redirect is dropped
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            if_id_pc    <= 32'h00000000;
            if_id_pc4   <= 32'h00000000;
            if_id_inst  <= BUBBLE_INST;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_pc    <= pc_p0;
            if_id_pc4   <= pc_inc(pc_p0);
            if_id_inst  <= rom_inst;
            if_id_valid <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= 32'h00000000;
            stall_cnt <= 32'h00000000;
        end else begin
            if (advance)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall && !redirect)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed vectors with hand-computed IF/ID results.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] if_id_pc, if_id_pc4, if_id_inst;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    logic [31:0] rom [0:63];

    typedef struct {
        logic [31:0] ra;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] inst;
        logic        vld;
        logic        cc;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_no = 0;

    always #5 clk = ~clk;

    assign rom_inst = rom[rom_addr[7:2]];

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL edge%0d %s: got %h expected %h", edge_no, name, act, exp);
        end
    endtask

    // Monitor: IF/ID updates on every edge, so one expectation is retired per cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            edge_no++;
            chk32("rom_addr", rom_addr, e.ra);
            chk32("if_id_pc", if_id_pc, e.ipc);
            chk32("if_id_pc4", if_id_pc4, e.ipc4);
            chk32("if_id_inst", if_id_inst, e.inst);
            chk32("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.vld});
`ifdef IF_PERF_CNT_EN
            if (e.cc) begin
                chk32("fetch_cnt", fetch_cnt, e.fc);
                chk32("stall_cnt", stall_cnt, e.sc);
            end
`endif
        end
    end

    task automatic stepc(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                         input logic [31:0] ra, input logic [31:0] ipc, input logic [31:0] ipc4,
                         input logic [31:0] inst, input logic vld,
                         input logic cc, input logic [31:0] fc, input logic [31:0] sc);
        exp_t e;
        rst = r; stall = s; redirect = d; redirect_pc = rpc;
        e.ra = ra; e.ipc = ipc; e.ipc4 = ipc4; e.inst = inst; e.vld = vld;
        e.cc = cc; e.fc = fc; e.sc = sc;
        q.push_back(e);
        @(posedge clk);
        #6;
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                        input logic [31:0] ra, input logic [31:0] ipc, input logic [31:0] ipc4,
                        input logic [31:0] inst, input logic vld);
        stepc(r, s, d, rpc, ra, ipc, ipc4, inst, vld, 1'b0, 32'h0, 32'h0);
    endtask

    localparam logic [31:0] W0 = 32'h00100443, W1 = 32'h00201025, W2 = 32'h041018E1,
                            W3 = 32'h04202021, W4 = 32'h380041A2, W63 = 32'hA500003F;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA5000000 | i;
        rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = W3; rom[4] = W4;

        // reset state
        step(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        // first fetches
        step(0, 0, 0, 32'h0, 32'h4, 32'h0, 32'h4, W0, 1);
        step(0, 0, 0, 32'h0, 32'h8, 32'h4, 32'h8, W1, 1);
        // three-cycle stall at pc=0x8
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'h0, 32'h8, 32'h4, 32'h8, W1, 1);
        step(0, 0, 0, 32'h0, 32'hC, 32'h8, 32'hC, W2, 1);
        // misaligned redirect to 0xE lands on 0xC
        step(0, 0, 1, 32'h0000000E, 32'hC, 32'h0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h10, 32'hC, 32'h10, W3, 1);
        // redirect beats stall
        step(0, 1, 1, 32'h00000010, 32'h10, 32'h0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h14, 32'h10, 32'h14, W4, 1);
        // ROM aliasing past 0xFC
        step(0, 0, 1, 32'h000000FC, 32'hFC, 32'h0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h100, 32'hFC, 32'h100, W63, 1);
        step(0, 0, 0, 32'h0, 32'h104, 32'h100, 32'h104, W0, 1);
        // 32-bit wrap of pc + 4
        step(0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, W63, 1);
        step(0, 0, 0, 32'h0, 32'h4, 32'h0, 32'h4, W0, 1);
        step(0, 0, 0, 32'h0, 32'h8, 32'h4, 32'h8, W1, 1);
        // reset wins over stall, and over redirect
        stepc(1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 32'd0, 32'd0);
        step(0, 0, 0, 32'h0, 32'h4, 32'h0, 32'h4, W0, 1);
        stepc(1, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 32'd0, 32'd0);
        // counter phase: 10 advances, 4 stalls, 1 redirect
        stepc(0, 0, 0, 32'h0, 32'h4,  32'h0,  32'h4,  W0, 1, 1, 32'd1, 32'd0);
        stepc(0, 0, 0, 32'h0, 32'h8,  32'h4,  32'h8,  W1, 1, 1, 32'd2, 32'd0);
        stepc(0, 0, 0, 32'h0, 32'hC,  32'h8,  32'hC,  W2, 1, 1, 32'd3, 32'd0);
        stepc(0, 0, 0, 32'h0, 32'h10, 32'hC,  32'h10, W3, 1, 1, 32'd4, 32'd0);
        stepc(0, 0, 0, 32'h0, 32'h14, 32'h10, 32'h14, W4, 1, 1, 32'd5, 32'd0);
        for (int i = 1; i <= 4; i++)
            stepc(0, 1, 0, 32'h0, 32'h14, 32'h10, 32'h14, W4, 1, 1, 32'd5, i);
        stepc(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 32'd5, 32'd4);
        stepc(0, 0, 0, 32'h0, 32'h4,  32'h0,  32'h4,  W0, 1, 1, 32'd6,  32'd4);
        stepc(0, 0, 0, 32'h0, 32'h8,  32'h4,  32'h8,  W1, 1, 1, 32'd7,  32'd4);
        stepc(0, 0, 0, 32'h0, 32'hC,  32'h8,  32'hC,  W2, 1, 1, 32'd8,  32'd4);
        stepc(0, 0, 0, 32'h0, 32'h10, 32'hC,  32'h10, W3, 1, 1, 32'd9,  32'd4);
        stepc(0, 0, 0, 32'h0, 32'h14, 32'h10, 32'h14, W4, 1, 1, 32'd10, 32'd4);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined CPU: owns the program counter, drives the word address into the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It is the requesting side of the ROM interface and honours load-use stalls from the hazard unit and branch/jump redirects from EX. Output feeds the ID stage decoder and register-file read.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset
- BUBBLE_INST, 32'h00000000, instruction word inserted into IF/ID on redirect or reset
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- rom_addr  out  32  byte address to ROM; ROM decodes bits [7:2] only
- rom_inst  in  32  combinational ROM read data for rom_addr
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  EX: branch taken / jump
- redirect_pc  in  32  target byte address
- if_id_pc  out  32  PC of captured instruction
- if_id_pc4  out  32  if_id_pc + 4
- if_id_inst  out  32  captured instruction
- if_id_valid  out  1  1 = real instruction, 0 = bubble

## Operation
- rom_addr = pc (combinational from PC register, no extra stage).
- Per-edge priority: rst > redirect > stall > advance.
- rst: pc <= RESET_PC; if_id_pc <= 0, if_id_pc4 <= 0, if_id_inst <= BUBBLE_INST, if_id_valid <= 0.
- redirect: pc <= {redirect_pc[31:2], 2'b00} (misaligned low bits dropped); IF/ID loaded with bubble (inst BUBBLE_INST, valid 0, pc/pc4 = 0). Instruction fetched this cycle is discarded. redirect overrides a concurrent stall.
- stall (no redirect): pc and all IF/ID outputs hold.
- advance: if_id_pc <= pc, if_id_pc4 <= pc + 4, if_id_inst <= rom_inst, if_id_valid <= 1; pc <= pc + 4.
- Arithmetic: pc + 4 is 32-bit modulo 2^32; 0xFFFFFFFC wraps to 0x00000000. No ROM-size check: addresses above 0xFC alias via rom_addr[7:2].
- No internal FSM beyond PC/IF-ID registers; only state is pc, IF/ID, and optional counters.

## Timing
- Fetch latency: instruction at address A appears on if_id_inst on the edge ending the cycle in which pc == A (1 cycle).
- Redirect penalty: 1 bubble in IF/ID; target instruction valid in IF/ID 2 edges after redirect sampled.
- Stall of N cycles holds IF/ID for N cycles; advance resumes the next cycle with the held pc.
- rst asserted mid-run takes effect on the next edge regardless of stall/redirect; first valid instruction (RESET_PC) appears one edge after rst deasserts.
- All outputs registered except rom_addr (= pc register, glitch-free).

## Configuration
- IF_PERF_CNT_EN defined: adds outputs fetch_cnt (32) and stall_cnt (32). fetch_cnt increments on each advance edge; stall_cnt increments on each edge with stall=1 and redirect=0; both cleared by rst, wrap modulo 2^32.
- Not defined: ports and counters absent; remaining behaviour identical.

## Test plan
- Reset then run with ROM word0=0x00100443, word1=0x00201025 -> edge1: if_id_pc=0x0, if_id_inst=0x00100443, valid=1; edge2: if_id_pc=0x4, if_id_pc4=0x8, inst=0x00201025.
- stall high 3 cycles while pc=0x8 -> IF/ID and rom_addr unchanged for 3 edges; next edge if_id_pc=0x8, inst=word2 (0x041018E1).
- redirect with redirect_pc=0x0000000E -> pc=0xC; next edge IF/ID valid=0, inst=0x00000000; following edge if_id_pc=0xC, inst=0x04202021.
- redirect and stall asserted together, redirect_pc=0x10 -> redirect wins: bubble in IF/ID, pc=0x10, next valid inst=0x380041A2.
- pc=0xFC advancing -> if_id_pc=0xFC, then if_id_pc=0x100 with inst=ROM word0 (0x00100443); rst asserted while stall=1 -> next edge pc=RESET_PC, valid=0, counters (IF_PERF_CNT_EN) = 0.
- IF_PERF_CNT_EN: 10 advances, 4 stalls, 1 redirect from reset -> fetch_cnt=10, stall_cnt=4.
